c_trace_monitor: RTL
====================

Name: c_trace_monitor

Overview:
- Downstream consumer of the arithmetic top's 11-bit result `c`. It samples `c` together with the `selector` value that produced it.
- Running statistics: min, max, sample count, and monotonicity candidates.
- Each sample is pushed, with a direction tag, into a small trace FIFO. A valid/ready port drains the FIFO to the property-mining trace writer.
- Runs in the same clock domain as the top.

Parameters:
- W, 11, data width of `c`
- DEPTH, 8, trace FIFO entries (power of two, ≥2)
- CNT_W, 16, width of the sample and drop counters

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- sample_en  in  1  sample `c_in`/`sel_in` this cycle
- c_in  in  W  result `c` from the top
- sel_in  in  1  selector value that produced `c_in`
- out_ready  in  1  trace sink ready
- out_valid  out  1  FIFO head valid
- out_data  out  W+3  {sel, dir[1:0], c} at FIFO head
- c_min  out  W  minimum sampled value
- c_max  out  W  maximum sampled value
- sample_cnt  out  CNT_W  accepted samples, saturating
- drop_cnt  out  CNT_W  samples lost to a full FIFO, saturating
- mono_up  out  1  `c` has never decreased since the first sample
- mono_dn  out  1  `c` has never increased since the first sample
- overflow  out  1  sticky; set on the first drop

Behaviour:
- Reset is synchronous; `rst` has priority over every event in the same cycle. Reset values:
  - out_valid=0, out_data=0
  - c_min={W{1}}, c_max=0
  - sample_cnt=0, drop_cnt=0
  - mono_up=1, mono_dn=1, overflow=0
  - FSM=EMPTY; FIFO pointers and count = 0
- FSM, two states:
  - EMPTY: no sample seen yet.
  - TRACK: entered on the first `sample_en`; left only by reset.
- Direction tag `dir`, computed against the previous sampled `c` (`prev_c`, one register updated on every sample):
  - FIRST=2'b11 for the first sample after reset
  - EQ=2'b00 when c_in==prev_c
  - UP=2'b01 when c_in>prev_c
  - DN=2'b10 when c_in<prev_c
  - Comparison is unsigned, W bits. No wrap detection: 2047→0 is DN.
- Statistics: on `sample_en`, all update at the next clock edge.
  - c_min=min(c_min, c_in); c_max=max(c_max, c_in).
  - sample_cnt increments, saturating at all-ones.
  - dir==DN clears mono_up; dir==UP clears mono_dn. Both are sticky until reset.
  - Statistics update whether or not the FIFO accepts the sample.
- Trace FIFO:
  - Push on `sample_en`. Pop when out_valid && out_ready.
  - out_data is the registered FIFO head. There is no same-cycle bypass: a push into an empty FIFO raises out_valid on the next cycle.
  - Full and push without pop: the sample is dropped, drop_cnt increments (saturating), overflow is set. FIFO contents are unchanged.
  - Full with simultaneous push and pop: both succeed; count stays DEPTH.
  - Empty with pop request: impossible, since out_valid=0.
  - Pointers wrap modulo DEPTH. Count is tracked in a separate $clog2(DEPTH)+1-bit register.
  - out_valid=(count!=0). out_data holds its value while out_valid && !out_ready.
- Latency: sample to head-of-empty-FIFO is 1 cycle; sample to statistics outputs is 1 cycle.
- Reset mid-operation: the FIFO is flushed, statistics return to reset values, and the next sample is tagged FIRST.

Decomposition:
- Shared package `c_trace_pkg`:
  - localparams DIR_EQ, DIR_UP, DIR_DN, DIR_FIRST
  - a typedef for the trace entry {sel, dir, c}
  - W is kept as a parameter, not a package constant.
- Sub-module `trace_fifo`: a synchronous, parameterised DEPTH×(W+3) FIFO.
  - Inputs: push, pop. Outputs: full, empty, count, head.
  - Reused by other cases' monitors.
- The top level holds the FSM, the comparators and the counters.

Test Plan:
- Reset, then samples c=5,9,9,3 with sel=1,0,1,0 and out_ready=1 → out_data entries:
  - {1,FIRST,5}, {0,UP,9}, {1,EQ,9}, {0,DN,3}
  - finally c_min=3, c_max=9, mono_up=0, mono_dn=0, sample_cnt=4.
- out_ready=0, 10 consecutive samples with DEPTH=8 → 8 stored, drop_cnt=2, overflow=1. Then out_ready=1 → exactly the first 8 samples drain in order.
- FIFO full, then sample_en and out_ready=1 in the same cycle → no drop, count stays 8, the new sample lands at the tail.
- Monotonic ramp 0..20 → mono_up=1, mono_dn=0, c_max=20. Then sample 2047 followed by 0 → the 0 is tagged DN and mono_up=0.
- rst asserted in the same cycle as sample_en with 3 entries queued → the next cycle has out_valid=0 and sample_cnt=0. The next sample is tagged FIRST.
- Force sample_cnt to 16'hFFFF and sample again → it holds at 16'hFFFF.

Source files
------------

// File: rtl/c_trace_pkg.sv
// Shared types for the c trace monitor: direction tags, trace tag
// layout and the monitor FSM states.
package c_trace_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_EQ    = 2'b00;
    localparam dir_t DIR_UP    = 2'b01;
    localparam dir_t DIR_DN    = 2'b10;
    localparam dir_t DIR_FIRST = 2'b11;

    // Upper bits of a trace entry; the entry is {tag, c} with c W bits.
    typedef struct packed {
        logic sel;
        dir_t dir;
    } trace_tag_t;

    localparam int TAG_W = $bits(trace_tag_t);

    typedef enum logic {
        ST_EMPTY,
        ST_TRACK
    } state_t;

    // Unsigned compare of a new sample against the previous one.
    function automatic dir_t classify(input logic first,
                                      input logic gt,
                                      input logic lt);
        dir_t d;
        d = DIR_EQ;
        unique case (1'b1)
            first:   d = DIR_FIRST;
            gt:      d = DIR_UP;
            lt:      d = DIR_DN;
            default: d = DIR_EQ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/c_trace_monitor_if.sv
// Valid/ready trace stream from the monitor to the trace writer.
// Ports: out_valid/out_data from master, out_ready from slave.
interface c_trace_monitor_if #(
    parameter int W = 11
);

    logic           out_valid;
    logic           out_ready;
    logic [W+2:0]   out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous DEPTH x DW FIFO with a registered head word.
// Ports: push/din in, pop in, full/empty/count/head out.
module trace_fifo #(
    parameter int DW    = 14,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DW-1:0]            head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rd_nx;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] head_q;
    logic          do_push;
    logic          do_pop;
    logic          last;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = head_q;
    assign rd_nx   = rd_q + AW'(1);
    assign last    = (cnt_q == CW'(1));

    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_nx;
            end

            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase

            // Head is its own register: a push into an empty (or
            // emptying) FIFO lands directly there, otherwise a pop
            // pulls the next stored word forward.
            if (do_push && (empty || (do_pop && last))) begin
                head_q <= din;
            end else if (do_pop && last) begin
                head_q <= '0;
            end else if (do_pop) begin
                head_q <= mem[rd_nx];
            end
        end
    end

endmodule

// File: rtl/c_trace_monitor.sv
// Samples result c with its selector, keeps running min/max, counts
// and monotonicity flags, and queues tagged samples for the trace
// writer.
// Ports: clk, rst, sample_en, c_in, sel_in, trace (valid/ready stream),
// c_min, c_max, sample_cnt, drop_cnt, mono_up, mono_dn, overflow.
module c_trace_monitor
    import c_trace_pkg::*;
#(
    parameter int W     = 11,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [W-1:0]        c_in,
    input  logic                sel_in,
    c_trace_monitor_if.master   trace,
    output logic [W-1:0]        c_min,
    output logic [W-1:0]        c_max,
    output logic [CNT_W-1:0]    sample_cnt,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic                mono_up,
    output logic                mono_dn,
    output logic                overflow
);

    localparam int DW = W + TAG_W;

    state_t             state_q;
    state_t             state_d;
    dir_t               dir;
    trace_tag_t         tag;
    logic [W-1:0]       prev_c_q;
    logic [W-1:0]       min_q;
    logic [W-1:0]       max_q;
    logic [CNT_W-1:0]   scnt_q;
    logic [CNT_W-1:0]   dcnt_q;
    logic               up_q;
    logic               dn_q;
    logic               ovf_q;

    logic               f_full;
    logic               f_empty;
    logic [$clog2(DEPTH):0] f_count;
    logic [DW-1:0]      f_head;
    logic               f_pop;
    logic               drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir     = DIR_FIRST;
        unique case (state_q)
            ST_EMPTY: begin
                dir = DIR_FIRST;
                if (sample_en) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                dir = classify(1'b0, c_in > prev_c_q, c_in < prev_c_q);
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    assign tag.sel = sel_in;
    assign tag.dir = dir;

    assign f_pop = trace.out_ready && !f_empty;

    // Drop only when full and the head is not leaving this cycle.
    assign drop  = sample_en && f_full && !f_pop;

    trace_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample_en),
        .din   ({tag, c_in}),
        .pop   (f_pop),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count),
        .head  (f_head)
    );

    assign trace.out_valid = (f_count != '0);
    assign trace.out_data  = f_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_c_q <= '0;
            min_q    <= '1;
            max_q    <= '0;
            scnt_q   <= '0;
            dcnt_q   <= '0;
            up_q     <= 1'b1;
            dn_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (sample_en) begin
                prev_c_q <= c_in;
                if (c_in < min_q) begin
                    min_q <= c_in;
                end
                if (c_in > max_q) begin
                    max_q <= c_in;
                end
                if (scnt_q != '1) begin
                    scnt_q <= scnt_q + CNT_W'(1);
                end
                if (dir == DIR_DN) begin
                    up_q <= 1'b0;
                end
                if (dir == DIR_UP) begin
                    dn_q <= 1'b0;
                end
            end
            if (drop) begin
                ovf_q <= 1'b1;
                if (dcnt_q != '1) begin
                    dcnt_q <= dcnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign c_min      = min_q;
    assign c_max      = max_q;
    assign sample_cnt = scnt_q;
    assign drop_cnt   = dcnt_q;
    assign mono_up    = up_q;
    assign mono_dn    = dn_q;
    assign overflow   = ovf_q;

endmodule
